// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both sides.
// Stage 1 captures the operands, stage 2 holds the result and its flags.
module logic_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             all_ones,
    output logic             parity,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] res;

    // in_ready is combinational from out_ready; there is no skid buffer.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    always_comb begin
        res = '0;
        case (s1_op)
            3'd0: res = s1_a & s1_b;
            3'd1: res = s1_a | s1_b;
            3'd2: res = s1_a ^ s1_b;
            3'd3: res = ~(s1_a | s1_b);
            3'd4: res = s1_a & ~s1_b;
            3'd5: res = ~(s1_a ^ s1_b);
            3'd6: res = s1_a;
            3'd7: res = ~s1_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= in1;
                s1_b  <= in2;
                s1_op <= op;
            end
        end
    end

    // Flags are derived from the stage-2 input so they line up with out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out      <= '0;
            zero     <= 1'b0;
            all_ones <= 1'b0;
            parity   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out      <= res;
                zero     <= (res == '0);
                all_ones <= &res;
                parity   <= ^res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (s2_valid && out_ready) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule
